// File: rtl/result_readout_ctrl.sv
// Result readout controller.
//
// Streams a block of result words out of a synchronous-read result memory
// onto a valid/ready stream. A 2-entry output FIFO absorbs the one-cycle
// memory read latency, so the block sustains one word per cycle when the
// consumer never stalls.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         one-cycle request to stream num_results words (IDLE only)
//   num_results   requested word count, clamped to MEM_SIZE, sampled with start
//   abort         cancel the transfer: flush the FIFO, drop in-flight data, no done
//   read_en       read strobe to the result memory
//   read_addr     read address, 0 for the first word of every transfer
//   result_in     memory read data, valid the cycle after read_en
//   m_data        stream data (FIFO head)
//   m_valid       stream valid (FIFO non-empty)
//   m_ready       stream accept from downstream
//   busy          high in READ and DRAIN
//   done          one-cycle pulse after the last word has been accepted
module result_readout_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned MEM_SIZE   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   num_results,
   input  logic                  abort,
   output logic                  read_en,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [DATA_WIDTH-1:0] result_in,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH:0] MemSizeC = (ADDR_WIDTH + 1)'(MEM_SIZE);
   localparam logic [ADDR_WIDTH:0] OneC     = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH:0]   total_q, total_d;    // clamped word count of this transfer
   logic [ADDR_WIDTH:0]   issued_q, issued_d;  // reads issued so far, doubles as address
   logic                  inflight_q;          // a read was issued last cycle

   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            count_q, count_d;

   logic                  push, pop, last_read;
   logic [2:0]            occ_after;

   // Stream side
   assign m_valid = (count_q != 2'd0);
   assign m_data  = fifo_q[rd_ptr_q];
   assign pop     = m_valid & m_ready;
   assign push    = inflight_q;
   assign count_d = count_q + {1'b0, push} - {1'b0, pop};

   // Occupancy the FIFO will have once the in-flight word lands and this
   // cycle's pop leaves; counting the pop is what allows back-to-back reads.
   assign occ_after = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};

   assign read_en   = (state_q == StRead) && !abort && (occ_after < 3'd2);
   assign read_addr = issued_q[ADDR_WIDTH-1:0];
   assign last_read = read_en && ((issued_q + OneC) == total_q);

   assign busy = (state_q == StRead) || (state_q == StDrain);
   assign done = (state_q == StDone);

   always_comb begin
      state_d  = state_q;
      total_d  = total_q;
      issued_d = issued_q + {{ADDR_WIDTH{1'b0}}, read_en};
      unique case (state_q)
         StIdle: begin
            if (start) begin
               total_d  = (num_results > MemSizeC) ? MemSizeC : num_results;
               issued_d = '0;
               state_d  = (num_results == '0) ? StDone : StRead;
            end
         end
         StRead: begin
            if (last_read) state_d = StDrain;
         end
         StDrain: begin
            if (count_q == 2'd0 && !inflight_q) state_d = StDone;
         end
         StDone: begin
            issued_d = '0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Abort wins over everything, including a same-cycle start.
      if (abort) begin
         state_d  = StIdle;
         issued_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         total_q  <= '0;
         issued_q <= '0;
      end else begin
         state_q  <= state_d;
         total_q  <= total_d;
         issued_q <= issued_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      end else if (abort) begin
         // Flush: the returning read data, if any, is simply never captured.
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         inflight_q <= read_en;
         count_q    <= count_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= result_in;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

endmodule

// File: tb/tb_result_readout_ctrl.sv
module tb_result_readout_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int MS = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   num_results = '0;
   logic          abort = 1'b0;
   logic          read_en;
   logic [AW-1:0] read_addr;
   logic [DW-1:0] result_in;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          busy;
   logic          done;

   result_readout_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MEM_SIZE   (MS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .num_results (num_results),
      .abort       (abort),
      .read_en     (read_en),
      .read_addr   (read_addr),
      .result_in   (result_in),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Result memory model: mem[i] = i + 10, one-cycle read latency.
   logic [DW-1:0] mem [MS];
   always @(posedge clk) if (read_en) result_in <= mem[read_addr];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard and monitor
   logic [DW-1:0] exp_q [$];
   int cyc = 0;
   int n_reads = 0, n_acc = 0, n_done = 0;
   int rd_first = 0, rd_last = 0, acc_first = 0, acc_last = 0;
   int first_addr = 0, last_addr = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", m_valid, 1);
            check("stall_data_stable", m_data, prev_data);
         end
         if (busy) check("outstanding_le_2", (n_reads - n_acc) <= 2, 1);
         if (read_en) begin
            check("read_addr_seq", read_addr, n_reads);
            if (n_reads == 0) begin
               rd_first   = cyc;
               first_addr = read_addr;
            end
            rd_last   = cyc;
            last_addr = read_addr;
            n_reads++;
         end
         if (m_valid && m_ready) begin
            check("sb_word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
            if (n_acc == 0) acc_first = cyc;
            acc_last = cyc;
            n_acc++;
         end
         if (done) n_done++;
         prev_stall = m_valid && !m_ready && !abort;
         prev_data  = m_data;
      end
   end

   task automatic launch(input int n, input int expect_n);
      n_reads = 0;
      n_acc   = 0;
      n_done  = 0;
      for (int i = 0; i < expect_n; i++) exp_q.push_back(8'(i + 10));
      @(posedge clk);
      #1 start = 1'b1;
      num_results = (AW + 1)'(n);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_within_budget", seen, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_low_after", busy, 0);
   endtask

   task automatic stream4(input string tag);
      m_ready = 1'b1;
      launch(4, 4);
      @(negedge clk);
      check({tag, "_read_en_after_E0"}, read_en, 1);
      check({tag, "_valid_before_E1"}, m_valid, 0);
      @(negedge clk);
      check({tag, "_valid_before_E2"}, m_valid, 0);
      @(negedge clk);
      check({tag, "_valid_after_E2"}, m_valid, 1);
      wait_done(50);
      check({tag, "_n_reads"}, n_reads, 4);
      check({tag, "_reads_consecutive"}, rd_last - rd_first, 3);
      check({tag, "_n_accepted"}, n_acc, 4);
      check({tag, "_words_consecutive"}, acc_last - acc_first, 3);
      check({tag, "_done_pulses"}, n_done, 1);
      check({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   logic [3:0] pat = 4'b1001;

   initial begin
      for (int i = 0; i < MS; i++) mem[i] = 8'(i + 10);

      // Reset state
      #1 check("reset_outputs", {read_en, read_addr, m_data, m_valid, busy, done}, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("idle_outputs", {read_en, m_valid, busy, done}, 0);

      // Basic stream with latency checks
      stream4("stream");

      // Backpressure with m_ready pattern 1,0,0,1
      m_ready = 1'b1;
      launch(4, 4);
      for (int c = 0; c < 80; c++) begin
         @(posedge clk);
         #1 m_ready = pat[c % 4];
         if (n_done > 0) break;
      end
      m_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("bp_n_reads", n_reads, 4);
      check("bp_n_accepted", n_acc, 4);
      check("bp_done_pulses", n_done, 1);
      check("bp_sb_empty", exp_q.size(), 0);
      check("bp_busy_low", busy, 0);

      // Zero count: straight to DONE, no reads
      launch(0, 0);
      @(negedge clk);
      check("zero_done", done, 1);
      check("zero_no_read", read_en, 0);
      check("zero_not_busy", busy, 0);
      @(negedge clk);
      check("zero_done_cleared", done, 0);
      check("zero_n_reads", n_reads, 0);

      // Clamp: 20 requested, 16 available
      launch(20, 16);
      wait_done(100);
      check("clamp_n_reads", n_reads, 16);
      check("clamp_last_addr", last_addr, 15);
      check("clamp_n_accepted", n_acc, 16);
      check("clamp_sb_empty", exp_q.size(), 0);

      // Abort after two accepted words with m_ready low
      m_ready = 1'b1;
      launch(8, 8);
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (n_acc >= 2) break;
      end
      check("abort_two_accepted", n_acc, 2);
      m_ready = 1'b0;
      abort   = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("abort_m_valid", m_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_read_addr", read_addr, 0);
      repeat (5) @(negedge clk);
      check("abort_no_done", n_done, 0);
      exp_q.delete();
      m_ready = 1'b1;
      launch(2, 2);
      wait_done(50);
      check("post_abort_first_addr", first_addr, 0);
      check("post_abort_n_accepted", n_acc, 2);
      check("post_abort_sb_empty", exp_q.size(), 0);

      // Start during READ is ignored
      launch(4, 4);
      @(posedge clk);
      #1 start = 1'b1;
      num_results = 5'd9;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(50);
      repeat (3) @(negedge clk);
      check("ign_n_reads", n_reads, 4);
      check("ign_n_accepted", n_acc, 4);
      check("ign_done_pulses", n_done, 1);
      check("ign_sb_empty", exp_q.size(), 0);

      // Reset while in DRAIN
      m_ready = 1'b0;
      launch(2, 2);
      repeat (4) @(posedge clk);
      #1 check("rst_mid_busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1 check("rst_mid_outputs", {read_en, read_addr, m_data, m_valid, busy, done}, 0);
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      stream4("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/result_readout_ctrl.md
RESULT_READOUT_CTRL -- requirements
Module: result_readout_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one stored result word.
REQ-002 Parameter ADDR_WIDTH, default 4: result memory address width.
REQ-003 Parameter MEM_SIZE, default 16: number of addressable result words; SHALL NOT exceed 2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all logic SHALL sample on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to stream results; one-cycle pulse.
REQ-007 num_results  input  ADDR_WIDTH+1  count of words to stream, sampled with start.
REQ-008 abort  input  1  cancel the current readout.
REQ-009 read_en  output  1  read strobe to result memory.
REQ-010 read_addr  output  ADDR_WIDTH  read address to result memory.
REQ-011 result_in  input  DATA_WIDTH  memory read data, valid the cycle after read_en.
REQ-012 m_data  output  DATA_WIDTH  streamed result word.
REQ-013 m_valid  output  1  m_data valid.
REQ-014 m_ready  input  1  downstream accept.
REQ-015 busy  output  1  high while in READ or DRAIN.
REQ-016 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 FSM states SHALL be IDLE, READ, DRAIN, DONE.
REQ-018 IDLE: start=1 with num_results>0 SHALL go to READ, with num_results=0 SHALL go to DONE; start SHALL be ignored in every other state.
REQ-019 Effective count SHALL be min(num_results, MEM_SIZE), latched at start.
REQ-020 Output buffer SHALL be a 2-entry FIFO; read_en SHALL assert only in READ and only when FIFO occupancy plus in-flight reads is below 2.
REQ-021 read_addr SHALL be 0 for the first read and SHALL increment by 1 after each read_en; it SHALL NOT wrap within a transfer.
REQ-022 result_in SHALL be written into the FIFO exactly one cycle after its read_en.
REQ-023 READ SHALL go to DRAIN in the cycle after the last read_en is issued.
REQ-024 m_valid SHALL equal FIFO non-empty; m_data SHALL be the FIFO head.
REQ-025 A transfer SHALL occur when m_valid and m_ready are both 1; m_data SHALL remain stable while m_valid=1 and m_ready=0.
REQ-026 FIFO push and pop in the same cycle SHALL both take effect; occupancy SHALL be unchanged.
REQ-027 With m_ready held at 1, the block SHALL sustain one word per cycle.
REQ-028 Latency: if start is sampled at edge E0, read_en SHALL be 1 during the cycle after E0, and m_valid SHALL be 1 after edge E2.
REQ-029 DRAIN SHALL go to DONE once the FIFO is empty and no read is in flight.
REQ-030 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-031 abort=1 in any state SHALL force IDLE at the next edge.
REQ-032 On abort, the FIFO SHALL be flushed, in-flight data discarded, read_addr reset to 0, and no done pulse generated.
REQ-033 abort SHALL take priority over start in the same cycle.

Reset
REQ-034 While rst_n=0: state=IDLE, FIFO empty, no read in flight.
REQ-035 While rst_n=0, every output SHALL be 0: read_en, read_addr, m_data, m_valid, busy, done.
REQ-036 Reset asserted mid-transfer SHALL discard all progress; the first start after reset SHALL stream again from address 0.

Verification
REQ-037 Stream: memory[i]=i+10, start with num_results=4, m_ready=1 -> read_addr 0,1,2,3 on consecutive cycles; m_data 10,11,12,13 on consecutive cycles; done pulses once; busy low after.
REQ-038 Backpressure: num_results=4, m_ready toggling 1,0,0,1,... -> no word lost or duplicated, m_data stable while stalled, at most 2 reads outstanding plus buffered.
REQ-039 Zero/clamp: num_results=0 -> no read_en, done pulses 2 cycles after start; num_results=20 with MEM_SIZE=16 -> exactly 16 reads, last read_addr 15.
REQ-040 Abort: abort after 2 words accepted, m_ready=0 -> next cycle m_valid=0, busy=0, no done pulse; a new start reads from address 0.
REQ-041 Ignored start: start pulsed during READ -> transfer count and addresses unaffected.
REQ-042 Reset mid-transfer: rst_n low during DRAIN -> all outputs 0 immediately (asynchronous); the following start behaves as in REQ-037.
